decode_stage: RTL and testbench

Decode stage of the five-stage pipeline: consumes InstructionD from the fetch/decode flip-flop and PCPlus8 from Fetch, reads a 15-entry register file (R15 reads as PCPlus8), and decodes control. It detects load-use hazards and registers everything into the decode/execute pipeline register feeding Execute. Write-back from the last stage enters through a dedicated write port.

---
 rtl/decode_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage: register file, control decode, load-use stall, D/E pipeline register.
// Optional macro DECODE_BYPASS_EN makes write-back data visible to reads in the same cycle.
module decode_stage #(
    parameter int WIDTH = 32,
    parameter int NREGS = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] InstructionD,
    input  logic [WIDTH-1:0] PCPlus8D,
    input  logic             RegWriteW,
    input  logic [3:0]       WA3W,
    input  logic [WIDTH-1:0] ResultW,
    input  logic             FlushE,
    output logic             StallF,
    output logic             StallD,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             MemToRegE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic [1:0]       ALUControlE,
    output logic [1:0]       FlagWriteE,
    output logic [3:0]       CondE,
    output logic [WIDTH-1:0] RD1E,
    output logic [WIDTH-1:0] RD2E,
    output logic [WIDTH-1:0] ExtImmE,
    output logic [3:0]       WA3E
);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;
    localparam logic [3:0] PC_REG  = 4'd15;

    logic [WIDTH-1:0] rf_q [NREGS];

    logic [1:0]       op;
    logic [5:0]       funct;
    logic [3:0]       cmd;
    logic [3:0]       rn;
    logic [3:0]       rd;
    logic [3:0]       rm;

    logic             dec_valid;
    logic             regwrite_d;
    logic             memwrite_d;
    logic             memtoreg_d;
    logic             branch_d;
    logic             alusrc_d;
    logic [1:0]       aluctl_d;
    logic [1:0]       flagwrite_d;
    logic [WIDTH-1:0] extimm_d;
    logic [3:0]       ra1;
    logic [3:0]       ra2;
    logic             use1;
    logic             use2;
    logic [WIDTH-1:0] rd1_d;
    logic [WIDTH-1:0] rd2_d;
    logic             stall;
    logic             bubble;

    logic             regwrite_q;
    logic             memwrite_q;
    logic             memtoreg_q;
    logic             branch_q;
    logic             alusrc_q;
    logic [1:0]       aluctl_q;
    logic [1:0]       flagwrite_q;
    logic [3:0]       cond_q;
    logic [WIDTH-1:0] rd1_q;
    logic [WIDTH-1:0] rd2_q;
    logic [WIDTH-1:0] extimm_q;
    logic [3:0]       wa3_q;

    assign op    = InstructionD[27:26];
    assign funct = InstructionD[25:20];
    assign cmd   = funct[4:1];
    assign rn    = InstructionD[19:16];
    assign rd    = InstructionD[15:12];
    assign rm    = InstructionD[3:0];

    always_comb begin
        dec_valid   = 1'b0;
        regwrite_d  = 1'b0;
        memwrite_d  = 1'b0;
        memtoreg_d  = 1'b0;
        branch_d    = 1'b0;
        alusrc_d    = 1'b0;
        aluctl_d    = ALU_ADD;
        flagwrite_d = 2'b00;
        extimm_d    = '0;
        ra1         = rn;
        ra2         = rm;
        use1        = 1'b0;
        use2        = 1'b0;
        case (op)
            2'b00: begin
                dec_valid = 1'b1;
                case (cmd)
                    4'b0100: aluctl_d = ALU_ADD;
                    4'b0010: aluctl_d = ALU_SUB;
                    4'b0000: aluctl_d = ALU_AND;
                    4'b1100: aluctl_d = ALU_ORR;
                    default: dec_valid = 1'b0;
                endcase
                if (dec_valid) begin
                    regwrite_d  = 1'b1;
                    alusrc_d    = funct[5];
                    extimm_d    = {{(WIDTH-8){1'b0}}, InstructionD[7:0]};
                    flagwrite_d = {funct[0], funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010))};
                    use1        = 1'b1;
                    use2        = ~funct[5];
                end
            end
            2'b01: begin
                dec_valid = 1'b1;
                alusrc_d  = 1'b1;
                aluctl_d  = funct[3] ? ALU_ADD : ALU_SUB;
                extimm_d  = {{(WIDTH-12){1'b0}}, InstructionD[11:0]};
                use1      = 1'b1;
                if (funct[0]) begin
                    regwrite_d = 1'b1;
                    memtoreg_d = 1'b1;
                end else begin
                    memwrite_d = 1'b1;
                    ra2        = rd;
                    use2       = 1'b1;
                end
            end
            2'b10: begin
                dec_valid = 1'b1;
                branch_d  = 1'b1;
                alusrc_d  = 1'b1;
                aluctl_d  = ALU_ADD;
                ra1       = PC_REG;
                extimm_d  = {{(WIDTH-26){InstructionD[23]}}, InstructionD[23:0], 2'b00};
            end
            default: dec_valid = 1'b0;
        endcase
    end

    // R15 is not a physical register: reads return PC+8 and it never takes part in hazards.
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (ra1 == PC_REG) begin
            rd1_d = PCPlus8D;
`ifdef DECODE_BYPASS_EN
        end else if (RegWriteW && (WA3W == ra1)) begin
            rd1_d = ResultW;
`endif
        end else begin
            rd1_d = rf_q[ra1];
        end
        if (ra2 == PC_REG) begin
            rd2_d = PCPlus8D;
`ifdef DECODE_BYPASS_EN
        end else if (RegWriteW && (WA3W == ra2)) begin
            rd2_d = ResultW;
`endif
        end else begin
            rd2_d = rf_q[ra2];
        end
    end

    always_comb begin
        stall = memtoreg_q & regwrite_q &
                ((use1 & (ra1 != PC_REG) & (ra1 == wa3_q)) |
                 (use2 & (ra2 != PC_REG) & (ra2 == wa3_q)));
    end

    assign StallF = stall;
    assign StallD = stall;
    assign bubble = stall | FlushE | ~dec_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (RegWriteW && (WA3W != PC_REG)) begin
            rf_q[WA3W] <= ResultW;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || bubble) begin
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            branch_q    <= 1'b0;
            alusrc_q    <= 1'b0;
            aluctl_q    <= 2'b00;
            flagwrite_q <= 2'b00;
            cond_q      <= 4'd0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            extimm_q    <= '0;
            wa3_q       <= 4'd0;
        end else begin
            regwrite_q  <= regwrite_d;
            memwrite_q  <= memwrite_d;
            memtoreg_q  <= memtoreg_d;
            branch_q    <= branch_d;
            alusrc_q    <= alusrc_d;
            aluctl_q    <= aluctl_d;
            flagwrite_q <= flagwrite_d;
            cond_q      <= InstructionD[31:28];
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            extimm_q    <= extimm_d;
            wa3_q       <= rd;
        end
    end

    assign RegWriteE   = regwrite_q;
    assign MemWriteE   = memwrite_q;
    assign MemToRegE   = memtoreg_q;
    assign BranchE     = branch_q;
    assign ALUSrcE     = alusrc_q;
    assign ALUControlE = aluctl_q;
    assign FlagWriteE  = flagwrite_q;
    assign CondE       = cond_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign ExtImmE     = extimm_q;
    assign WA3E        = wa3_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage against a reference model of the decode rules.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] InstructionD;
    logic [31:0] PCPlus8D;
    logic        RegWriteW;
    logic [3:0]  WA3W;
    logic [31:0] ResultW;
    logic        FlushE;
    logic        StallF, StallD;
    logic        RegWriteE, MemWriteE, MemToRegE, BranchE, ALUSrcE;
    logic [1:0]  ALUControlE, FlagWriteE;
    logic [3:0]  CondE, WA3E;
    logic [31:0] RD1E, RD2E, ExtImmE;

    decode_stage dut (
        .clock(clock), .reset(reset), .InstructionD(InstructionD), .PCPlus8D(PCPlus8D),
        .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW), .FlushE(FlushE),
        .StallF(StallF), .StallD(StallD), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemToRegE(MemToRegE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .FlagWriteE(FlagWriteE), .CondE(CondE), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
        .WA3E(WA3E)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [112:0] v;
        int           due;
    } e_exp_t;

    typedef struct {
        logic s;
        int   due;
    } s_exp_t;

    e_exp_t      e_q[$];
    s_exp_t      s_q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mregs [15];
    logic [112:0] prev_e;
    bit          prev_known = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        while (s_q.size() > 0 && s_q[0].due == cyc) begin
            s_exp_t s;
            s = s_q.pop_front();
            chk("StallD", {127'd0, StallD}, {127'd0, s.s});
            chk("StallF", {127'd0, StallF}, {127'd0, s.s});
        end
        while (e_q.size() > 0 && e_q[0].due == cyc) begin
            e_exp_t e;
            e = e_q.pop_front();
            chk("E_outputs",
                {15'd0, RegWriteE, MemWriteE, MemToRegE, BranchE, ALUSrcE, ALUControlE,
                 FlagWriteE, CondE, RD1E, RD2E, ExtImmE, WA3E},
                {15'd0, e.v});
        end
    end

    function automatic logic [31:0] mread(input logic [3:0] a, input logic [31:0] pc8,
                                          input logic we, input logic [3:0] wa, input logic [31:0] wd);
        if (a == 4'd15) return pc8;
`ifdef DECODE_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return mregs[a];
    endfunction

    function automatic logic [112:0] model_decode(input logic [31:0] ins, input logic [31:0] pc8,
                                                  input logic we, input logic [3:0] wa, input logic [31:0] wd);
        logic rw, mw, m2r, br, as;
        logic [1:0] alu, fw;
        logic [31:0] r1, r2, imm;
        logic [3:0] cmd;
        rw = 0; mw = 0; m2r = 0; br = 0; as = 0; alu = 0; fw = 0;
        r1 = mread(ins[19:16], pc8, we, wa, wd);
        r2 = mread(ins[3:0], pc8, we, wa, wd);
        cmd = ins[24:21];
        case (ins[27:26])
            2'b00: begin
                if (cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12) begin
                    rw = 1;
                    as = ins[25];
                    alu = (cmd == 4) ? 2'd0 : (cmd == 2) ? 2'd1 : (cmd == 0) ? 2'd2 : 2'd3;
                    fw = {ins[20], ins[20] && (cmd == 4 || cmd == 2)};
                    imm = {24'd0, ins[7:0]};
                end else begin
                    return '0;
                end
            end
            2'b01: begin
                as = 1;
                alu = ins[23] ? 2'd0 : 2'd1;
                imm = {20'd0, ins[11:0]};
                if (ins[20]) begin
                    rw = 1; m2r = 1;
                end else begin
                    mw = 1;
                    r2 = mread(ins[15:12], pc8, we, wa, wd);
                end
            end
            2'b10: begin
                br = 1; as = 1; alu = 0;
                r1 = pc8;
                imm = {{8{ins[23]}}, ins[23:0]} << 2;
            end
            default: return '0;
        endcase
        return {rw, mw, m2r, br, as, alu, fw, ins[31:28], r1, r2, imm, ins[15:12]};
    endfunction

    // A load in E blocks any instruction in D that reads the load's destination (not R15).
    function automatic logic model_hazard(input logic [31:0] ins, input logic [112:0] pe);
        logic [3:0] srcs[$];
        logic pe_rw, pe_m2r;
        logic [3:0] pe_wa;
        pe_rw = pe[112];
        pe_m2r = pe[110];
        pe_wa = pe[3:0];
        case (ins[27:26])
            2'b00: if (ins[24:21] inside {4'd4, 4'd2, 4'd0, 4'd12}) begin
                srcs.push_back(ins[19:16]);
                if (!ins[25]) srcs.push_back(ins[3:0]);
            end
            2'b01: begin
                srcs.push_back(ins[19:16]);
                if (!ins[20]) srcs.push_back(ins[15:12]);
            end
            default: ;
        endcase
        if (!(pe_rw && pe_m2r)) return 1'b0;
        foreach (srcs[i]) if (srcs[i] != 4'd15 && srcs[i] == pe_wa) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic rst_n, input logic [31:0] ins, input logic [31:0] pc8,
                        input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic fl, output logic stall_o);
        logic [112:0] e;
        reset = rst_n; InstructionD = ins; PCPlus8D = pc8;
        RegWriteW = we; WA3W = wa; ResultW = wd; FlushE = fl;
        stall_o = prev_known ? model_hazard(ins, prev_e) : 1'b0;
        if (prev_known) s_q.push_back('{s: stall_o, due: cyc});
        if (!rst_n || stall_o || fl) e = '0;
        else e = model_decode(ins, pc8, we, wa, wd);
        e_q.push_back('{v: e, due: cyc + 1});
        prev_e = e;
        prev_known = 1;
        if (!rst_n) begin
            foreach (mregs[i]) mregs[i] = 32'd0;
        end else if (we && wa != 4'd15) begin
            mregs[wa] = wd;
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] rand_reg();
        if ($urandom_range(0, 7) == 0) return 4'd15;
        return 4'($urandom_range(0, 4));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [3:0] cmds[4];
        int k;
        cmds[0] = 4'd4; cmds[1] = 4'd2; cmds[2] = 4'd0; cmds[3] = 4'd12;
        ins = $urandom;
        k = $urandom_range(0, 9);
        if (k <= 3) begin
            ins[27:26] = 2'b00;
            ins[24:21] = cmds[$urandom_range(0, 3)];
        end else if (k <= 6) begin
            ins[27:26] = 2'b01;
        end else if (k == 7) begin
            ins[27:26] = 2'b10;
        end else if (k == 8) begin
            ins[27:26] = 2'b11;
        end
        if (ins[27:26] != 2'b10) begin
            ins[19:16] = rand_reg();
            ins[15:12] = rand_reg();
            ins[3:0]   = rand_reg();
        end
        return ins;
    endfunction

    initial begin
        logic st;
        logic [31:0] ins;
        step(0, 32'h0, 32'h0, 0, 0, 0, 0, st);
        step(0, 32'hE2801005, 32'h8, 1, 4'd3, 32'h1234, 0, st);
        step(1, 32'hE2801005, 32'h8, 0, 0, 0, 0, st);
        step(1, 32'hE5912004, 32'hC, 1, 4'd1, 32'h40, 0, st);
        step(1, 32'hE0823002, 32'h10, 0, 0, 0, 0, st);
        if (!st) begin
            n_chk++; n_fail++;
            $display("FAIL ldr_use_stall: got 0 expected 1");
        end
        step(1, 32'hE0823002, 32'h10, 0, 0, 0, 0, st);
        step(1, 32'hE3A00000, 32'h14, 1, 4'd4, 32'h11111111, 0, st);
        step(1, 32'hE0845004, 32'h18, 1, 4'd4, 32'hDEADBEEF, 0, st);
        step(1, 32'hE0845004, 32'h1C, 0, 0, 0, 0, st);
        step(1, 32'hEAFFFFFE, 32'h100, 0, 0, 0, 0, st);
        step(1, 32'hE2801005, 32'h104, 1, 4'd15, 32'hFFFFFFFF, 1, st);
        for (int r = 0; r < 15; r++) begin
            step(1, 32'hE1800000 | (32'(r) << 16) | 32'(r), 32'h200, 0, 0, 0, 0, st);
        end
        st = 0;
        ins = 32'h0;
        for (int n = 0; n < 1500; n++) begin
            logic rst_n, we, fl;
            if (!st) ins = rand_instr();
            rst_n = ($urandom_range(0, 199) != 0);
            we = $urandom_range(0, 1);
            fl = ($urandom_range(0, 7) == 0);
            step(rst_n, ins, $urandom, we, 4'($urandom_range(0, 15)), $urandom, fl, st);
        end
        @(negedge clock);
        #1;
        chk("queues_drained", 128'(e_q.size() + s_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
